mem_dbus: RTL and testbench
===========================

MEM_DBUS -- requirements
Module: mem_dbus

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  synchronous, active-high reset: 1 = reset, sampled only on rising clk.
REQ-003 ex_valid  in  1  EX/MEM register holds a live instruction.
REQ-004 ex_wd / ex_wreg / ex_wdata  in  5/1/32  GPR write address, write enable, ALU result.
REQ-005 ex_whilo / ex_hi / ex_lo  in  1/32/32  HI/LO write enable and values.
REQ-006 ex_mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-007 ex_mem_addr / ex_store_data  in  32/32  effective byte address, rt value for stores.
REQ-008 dbus_req / dbus_we  out  1/1  bus request, write strobe.
REQ-009 dbus_addr / dbus_sel / dbus_wdata  out  32/4/32  word address (bits 1:0 = 0), byte lanes, store data.
REQ-010 dbus_ack / dbus_rdata  in  1/32  one-cycle completion strobe, read data valid with ack.
REQ-011 stall_req  out  1  freeze IF..EX/MEM while a memory op is unfinished.
REQ-012 mem_wd / mem_wreg / mem_wdata / mem_whilo / mem_hi / mem_lo  out  5/1/32/1/32/32  feed MEM/WB register.
REQ-013 addr_err / bus_err  out  1/1  one-cycle exception pulses.

Function
REQ-014 Non-memory op (or ex_valid=0): mem_* = ex_* combinationally (mem_wreg = ex_wreg & ex_valid), stall_req=0, no bus activity.
REQ-015 States IDLE, BUSY, DONE; state, latched request and load result are registers.
REQ-016 IDLE, ex_valid, aligned memory op: stall_req=1 combinationally; next edge latch addr/sel/wdata/we, enter BUSY.
REQ-017 BUSY: dbus_req=1, outputs from latched registers, stall_req=1; on dbus_ack capture formatted load data, enter DONE.
REQ-018 DONE: stall_req=0, dbus_req=0; loads drive mem_wreg=1, mem_wdata=captured value; stores drive mem_wreg=0; next edge -> IDLE.
REQ-019 Latency: op presented cycle N, earliest ack N+1, DONE N+2, upstream advances at end of N+2.
REQ-020 Byte order big-endian: offset 0 -> bits 31:24, sel 4'b1000; offset 3 -> bits 7:0, sel 4'b0001; halfword offset 0 -> sel 4'b1100, offset 2 -> sel 4'b0011; word -> sel 4'b1111.
REQ-021 Stores replicate data across lanes: SB {4{b}}, SH {2{h}}, SW word; dbus_we=1.
REQ-022 Loads: LB/LH sign-extend, LBU/LHU zero-extend selected lane to 32 bits; LW passes word.
REQ-023 Misalignment (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no bus request, addr_err=1 for one cycle, mem_wreg=0, stall_req=0, state stays IDLE.
REQ-024 Timeout: 8-bit counter cleared on BUSY entry, increments each BUSY cycle without ack; reaching 255 drops dbus_req, pulses bus_err, enters DONE with mem_wreg=0.
REQ-025 dbus_ack in IDLE or DONE ignored; ack on the timeout cycle takes priority over timeout.
REQ-026 ex_* changes while in BUSY/DONE are ignored; latched values are used.

Reset
REQ-027 rst_n=1 at an edge: state IDLE, counter 0, latches 0; registered dbus_req/dbus_we/dbus_sel/dbus_addr/dbus_wdata=0, addr_err=bus_err=0, captured load data 0.
REQ-028 Reset mid-BUSY: dbus_req deasserts on that edge; no DONE cycle, no writeback of the aborted op.

Verification
REQ-029 LB addr 0x103, ack after 2 wait cycles, rdata 0x112233F4 -> sel 4'b0001 in BUSY, DONE mem_wdata 0xFFFFFFF4, mem_wreg=1, stall_req high exactly 4 cycles.
REQ-030 SH addr 0x202, data 0x0000ABCD -> dbus_wdata 0xABCDABCD, sel 4'b0011, we=1; DONE mem_wreg=0.
REQ-031 LW addr 0x101 -> addr_err pulse, no dbus_req, mem_wreg=0, stall_req=0.
REQ-032 LW with ack never asserted -> bus_err after 255 BUSY cycles, dbus_req low next cycle, mem_wreg=0 in DONE.
REQ-033 ADD result 0x5 to r3 with ex_whilo=1, hi=0x1, lo=0x2 -> same-cycle pass-through, stall_req=0.
REQ-034 rst_n=1 during BUSY of LHU -> dbus_req=0 next cycle, state IDLE, no mem_wreg pulse.

Source files
------------

// File: rtl/mem_dbus_if.sv
// Data-bus handshake between the MEM stage (master) and the memory system (slave).
interface mem_dbus_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_dbus.sv
// MEM stage: passes ALU results through, or runs one big-endian load/store on the
// data bus with alignment checking, a 255-cycle timeout and pipeline stall.
module mem_dbus (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_whilo,
  input  logic [31:0]       ex_hi,
  input  logic [31:0]       ex_lo,
  input  logic [3:0]        ex_mem_op,
  input  logic [31:0]       ex_mem_addr,
  input  logic [31:0]       ex_store_data,
  mem_dbus_if.master        dbus,
  output logic              stall_req,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [31:0]       mem_wdata,
  output logic              mem_whilo,
  output logic [31:0]       mem_hi,
  output logic [31:0]       mem_lo,
  output logic              addr_err,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
    OP_LW   = 4'd5, OP_SB = 4'd6, OP_SH  = 4'd7, OP_SW = 4'd8
  } mem_op_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [4:0]  wd_q, wd_d;
  logic        whilo_q, whilo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_load, is_store, misalign;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_fmt;
  logic        op_q_load;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    misalign  = 1'b0;
    req_sel   = 4'b1111;
    req_wdata = ex_store_data;
    case (ex_mem_op)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        req_sel = 4'b1000 >> ex_mem_addr[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load  = 1'b1;
        req_sel  = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
        misalign = ex_mem_addr[0];
      end
      OP_LW: begin
        is_load  = 1'b1;
        misalign = |ex_mem_addr[1:0];
      end
      OP_SB: begin
        is_store  = 1'b1;
        req_sel   = 4'b1000 >> ex_mem_addr[1:0];
        req_wdata = {4{ex_store_data[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        req_sel   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{ex_store_data[15:0]}};
        misalign  = ex_mem_addr[0];
      end
      OP_SW: begin
        is_store = 1'b1;
        misalign = |ex_mem_addr[1:0];
      end
      default: ;
    endcase
  end

  // Big-endian lane pick: offset 0 is the most significant byte of the word.
  always_comb begin
    case (off_q)
      2'd0:    byte_lane = dbus.dbus_rdata[31:24];
      2'd1:    byte_lane = dbus.dbus_rdata[23:16];
      2'd2:    byte_lane = dbus.dbus_rdata[15:8];
      default: byte_lane = dbus.dbus_rdata[7:0];
    endcase
    half_lane = off_q[1] ? dbus.dbus_rdata[15:0] : dbus.dbus_rdata[31:16];
    case (op_q)
      OP_LB:   load_fmt = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_fmt = {24'd0, byte_lane};
      OP_LH:   load_fmt = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_fmt = {16'd0, half_lane};
      default: load_fmt = dbus.dbus_rdata;
    endcase
    op_q_load = (op_q >= OP_LB) && (op_q <= OP_LW);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    op_d      = op_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    wd_d      = wd_q;
    whilo_d   = whilo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    stall_req = 1'b0;
    addr_err  = 1'b0;
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg & ex_valid;
    mem_wdata = ex_wdata;
    mem_whilo = ex_whilo;
    mem_hi    = ex_hi;
    mem_lo    = ex_lo;

    case (state_q)
      S_IDLE: begin
        if (ex_valid && (is_load || is_store)) begin
          mem_wreg = 1'b0;
          if (misalign) begin
            addr_err = 1'b1;
          end else begin
            stall_req = 1'b1;
            addr_d    = {ex_mem_addr[31:2], 2'b00};
            sel_d     = req_sel;
            wdata_d   = req_wdata;
            we_d      = is_store;
            op_d      = ex_mem_op;
            off_d     = ex_mem_addr[1:0];
            cnt_d     = '0;
            wd_d      = ex_wd;
            whilo_d   = ex_whilo;
            hi_d      = ex_hi;
            lo_d      = ex_lo;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        mem_wd    = wd_q;
        mem_wreg  = 1'b0;
        mem_whilo = 1'b0;
        mem_hi    = hi_q;
        mem_lo    = lo_q;
        // An ack arriving on the final allowed cycle still completes normally.
        if (dbus.dbus_ack) begin
          if (op_q_load) rdata_d = load_fmt;
          state_d = S_DONE;
        end else if (cnt_q == 8'd254) begin
          cnt_d     = 8'd255;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        mem_wd    = wd_q;
        mem_wreg  = op_q_load & ~bus_err_q;
        mem_wdata = rdata_q;
        mem_whilo = whilo_q;
        mem_hi    = hi_q;
        mem_lo    = lo_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      op_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      wd_q      <= '0;
      whilo_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      op_q      <= op_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      wd_q      <= wd_d;
      whilo_q   <= whilo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign dbus.dbus_req   = (state_q == S_BUSY);
  assign dbus.dbus_we    = (state_q == S_BUSY) & we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_sel   = sel_q;
  assign dbus.dbus_wdata = wdata_q;
  assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_dbus.sv
// Randomized bench for mem_dbus against a behavioural model of the MEM-stage rules.
module tb_mem_dbus;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi, ex_lo;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr, ex_store_data;
  logic        stall_req;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic        addr_err, bus_err;

  int total = 0;
  int bad   = 0;

  mem_dbus_if dbus ();

  mem_dbus dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_wdata(ex_wdata), .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .dbus(dbus), .stall_req(stall_req), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Model: access size in bytes (0 = not a memory op).
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_sel(input int sz, input logic [31:0] addr);
    int off = int'(addr % 4);
    return 4'(((1 << sz) - 1) << (4 - sz - off));
  endfunction

  function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
    logic [31:0] b = {24'd0, d[7:0]};
    logic [31:0] h = {16'd0, d[15:0]};
    if (sz == 1) return b * 32'h01010101;
    if (sz == 2) return h * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int sz = op_size(op);
    int off = int'(addr % 4);
    logic [31:0] mask;
    logic [31:0] v;
    if (sz == 4) return rd;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (rd >> (8 * (4 - sz - off))) & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_mem_op = 4'd0; ex_wreg = 1'b0; ex_whilo = 1'b0;
    dbus.dbus_ack = 1'b0; dbus.dbus_rdata = $urandom;
  endtask

  task automatic scramble_ex();
    ex_valid = 1'b1; ex_wd = 5'($urandom); ex_wreg = 1'($urandom);
    ex_wdata = $urandom; ex_mem_op = 4'($urandom); ex_mem_addr = $urandom;
    ex_store_data = $urandom; ex_hi = $urandom; ex_lo = $urandom;
  endtask

  task automatic check_passthrough(input string tag);
    check({tag, "_wd"}, 32'(mem_wd), 32'(ex_wd));
    check({tag, "_wreg"}, 32'(mem_wreg), 32'(ex_wreg & ex_valid));
    check({tag, "_wdata"}, mem_wdata, ex_wdata);
    check({tag, "_whilo"}, 32'(mem_whilo), 32'(ex_whilo));
    check({tag, "_hi"}, mem_hi, ex_hi);
    check({tag, "_lo"}, mem_lo, ex_lo);
    check({tag, "_stall"}, 32'(stall_req), 32'd0);
    check({tag, "_req"}, 32'(dbus.dbus_req), 32'd0);
    check({tag, "_aerr"}, 32'(addr_err), 32'd0);
  endtask

  // One memory op; waits >= 255 means the slave never acks.
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input int waits, input logic [31:0] rd, input logic [4:0] wd);
    int sz = op_size(op);
    logic ld = (op >= 4'd1 && op <= 4'd5);
    logic tmo = (waits >= 255);
    int stalls = 0;
    ex_valid = 1'b1; ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sd;
    ex_wd = wd; ex_wreg = ld; ex_wdata = $urandom; ex_whilo = 1'b0;
    dbus.dbus_ack = 1'($urandom); dbus.dbus_rdata = $urandom;
    #1;
    if ((addr % sz) != 0) begin
      check("mis_aerr", 32'(addr_err), 32'd1);
      check("mis_req", 32'(dbus.dbus_req), 32'd0);
      check("mis_stall", 32'(stall_req), 32'd0);
      check("mis_wreg", 32'(mem_wreg), 32'd0);
      next_cycle();
      idle_inputs();
      #1;
      check("mis_req_after", 32'(dbus.dbus_req), 32'd0);
      check("mis_aerr_after", 32'(addr_err), 32'd0);
      return;
    end
    check("launch_aerr", 32'(addr_err), 32'd0);
    check("launch_req", 32'(dbus.dbus_req), 32'd0);
    stalls += int'(stall_req);
    for (int i = 0; i <= waits && i < 255; i++) begin
      next_cycle();
      scramble_ex();
      dbus.dbus_ack   = (i == waits);
      dbus.dbus_rdata = (i == waits) ? rd : $urandom;
      #1;
      check("busy_req", 32'(dbus.dbus_req), 32'd1);
      check("busy_addr", dbus.dbus_addr, {addr[31:2], 2'b00});
      check("busy_sel", 32'(dbus.dbus_sel), 32'(exp_sel(sz, addr)));
      check("busy_we", 32'(dbus.dbus_we), 32'(!ld));
      if (!ld) check("busy_wdata", dbus.dbus_wdata, exp_wdata(sz, sd));
      stalls += int'(stall_req);
    end
    next_cycle();
    scramble_ex();
    dbus.dbus_ack = 1'($urandom);
    dbus.dbus_rdata = $urandom;
    #1;
    check("stall_cycles", 32'(stalls), tmo ? 32'd256 : 32'(waits + 2));
    check("done_stall", 32'(stall_req), 32'd0);
    check("done_req", 32'(dbus.dbus_req), 32'd0);
    check("done_berr", 32'(bus_err), 32'(tmo));
    check("done_wreg", 32'(mem_wreg), 32'(ld && !tmo));
    check("done_wd", 32'(mem_wd), 32'(wd));
    if (ld && !tmo) check("done_wdata", mem_wdata, exp_load(op, addr, rd));
    next_cycle();
    idle_inputs();
    #1;
    check("after_req", 32'(dbus.dbus_req), 32'd0);
    check("after_berr", 32'(bus_err), 32'd0);
    check("after_wreg", 32'(mem_wreg), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    ex_wd = '0; ex_wdata = '0; ex_hi = '0; ex_lo = '0; ex_mem_addr = '0; ex_store_data = '0;
    idle_inputs();
    repeat (2) next_cycle();
    check("rst_req", 32'(dbus.dbus_req), 32'd0);
    check("rst_we", 32'(dbus.dbus_we), 32'd0);
    check("rst_sel", 32'(dbus.dbus_sel), 32'd0);
    check("rst_addr", dbus.dbus_addr, 32'd0);
    check("rst_wdata", dbus.dbus_wdata, 32'd0);
    check("rst_berr", 32'(bus_err), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    rst_n = 1'b0;
    next_cycle();

    // ADD r3 <- 5 with HI/LO write
    ex_valid = 1'b1; ex_mem_op = 4'd0; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h5;
    ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
    #1;
    check_passthrough("add");
    check("add_wdata_const", mem_wdata, 32'h5);

    for (int i = 0; i < 12; i++) begin
      next_cycle();
      scramble_ex();
      ex_valid = 1'($urandom);
      ex_whilo = 1'($urandom);
      ex_mem_op = (i % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      if (!ex_valid) ex_mem_op = 4'($urandom);
      #1;
      check_passthrough("pass");
    end
    next_cycle();
    idle_inputs();

    run_mem(4'd1, 32'h103, 32'h0, 2, 32'h112233F4, 5'd7);
    run_mem(4'd7, 32'h202, 32'h0000ABCD, 1, 32'h0, 5'd0);
    run_mem(4'd5, 32'h101, 32'h0, 0, 32'h0, 5'd4);
    run_mem(4'd5, 32'h400, 32'h0, 255, 32'h0, 5'd9);
    run_mem(4'd2, 32'h401, 32'h0, 254, 32'h80C0FFEE, 5'd10);

    // Reset while an LHU is in flight
    ex_valid = 1'b1; ex_mem_op = 4'd4; ex_mem_addr = 32'h502; ex_wd = 5'd6; ex_wreg = 1'b1;
    next_cycle();
    scramble_ex();
    rst_n = 1'b1;
    dbus.dbus_ack = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rstbusy_req", 32'(dbus.dbus_req), 32'd0);
    check("rstbusy_stall", 32'(stall_req), 32'd0);
    check("rstbusy_wreg", 32'(mem_wreg), 32'd0);
    next_cycle();
    check("rstbusy_wreg2", 32'(mem_wreg), 32'd0);
    check("rstbusy_req2", 32'(dbus.dbus_req), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op = 4'($urandom_range(1, 8));
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        int s = op_size(op);
        a = a & ~(32'(s) - 32'd1);
      end
      run_mem(op, a, $urandom, int'($urandom_range(0, 3)), $urandom, 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
endmodule
